memory_access_stage: RTL
========================

// Module: memory_access_stage
// PURPOSE
//  MEM stage of the 5-stage MIPS pipeline; consumes the EX/MEM register outputs of the execute stage.
//  Resolves branches, accesses a word-addressed data RAM with configurable multi-cycle latency
//  (stalls upstream while busy), and drives the MEM/WB pipeline register consumed by write-back and forwarding.
// PARAMETERS
//  ADDR_W       6   word-address bits; RAM depth = 2**ADDR_W 32-bit words
//  MEM_LATENCY  2   extra wait cycles per load/store (0 = single-cycle access)
// PORTS
//  clock            in   1   rising-edge clock
//  reset            in   1   asynchronous, active-low reset
//  ip_ALU_result    in   32  EX/MEM ALU result; byte address for loads/stores
//  ip_Add_result    in   8   EX/MEM branch target
//  ip_memory_write_data in 32 store data
//  ip_dest_reg      in   5   destination register
//  ip_zero          in   1   ALU zero flag
//  ip_MemtoReg, ip_RegWrite, ip_read_en, ip_write_en, ip_branch  in 1 each  EX/MEM controls
//  op_PC_src        out  1   ip_branch & ip_zero (combinational)
//  op_branch_target out  8   ip_Add_result (combinational)
//  op_stall         out  1   freeze PC/IF/ID/EX and hold EX/MEM
//  op_misaligned    out  1   one-cycle pulse: access with ip_ALU_result[1:0]!=0
//  op_read_data     out  32  MEM/WB load data
//  op_ALU_result    out  32  MEM/WB ALU result
//  op_dest_reg      out  5   MEM/WB destination register
//  op_MemtoReg      out  1   MEM/WB write-back select
//  op_RegWrite      out  1   MEM/WB write enable
// BEHAVIOUR
//  - Reset (reset=0, async): state IDLE, wait counter 0, all registered outputs 0. op_stall forced 0
//    while reset is low. RAM contents are not cleared; RAM initialises to zero at elaboration.
//  - acc = ip_read_en | ip_write_en. Word index = ip_ALU_result[ADDR_W+1:2]; higher bits ignored (wraps).
//  - Misaligned access (acc & ip_ALU_result[1:0]!=0): no RAM access and no stall.
//    op_misaligned pulses 1 cycle. MEM/WB gets a bubble (RegWrite=0, MemtoReg=0, other fields 0).
//  - FSM IDLE / BUSY, 2-bit-min counter cnt.
//    IDLE, !acc: MEM/WB <= {0, ip_ALU_result, ip_dest_reg, ip_MemtoReg, ip_RegWrite}; op_stall=0.
//    IDLE, acc, MEM_LATENCY==0: access this edge; MEM/WB latches; op_stall=0.
//    IDLE, acc, MEM_LATENCY>0: op_stall=1; next BUSY, cnt<=MEM_LATENCY-1; MEM/WB <= bubble.
//    BUSY, cnt!=0: op_stall=1; cnt--; MEM/WB <= bubble.
//    BUSY, cnt==0: op_stall=0; access at this edge; MEM/WB latches; next IDLE.
//  - Upstream holds all ip_* stable while op_stall=1. op_stall is combinational from state, cnt and acc.
//  - A load or store occupies MEM_LATENCY+1 cycles. Load data reaches op_read_data on the completing edge.
//  - Store: RAM[idx] <= ip_memory_write_data on the completing edge. op_read_data=0 for stores.
//  - ip_read_en & ip_write_en together: treated as a store; op_read_data gets the pre-write word.
//  - Back-to-back accesses: the next access starts from IDLE the cycle after completion (no extra gap).
//  - Reset during BUSY: the access is abandoned, no RAM write, FSM goes to IDLE.
//  - op_PC_src and op_branch_target are not gated by op_stall (a branch never has acc=1).
// TESTING
//  1 Reset low mid-BUSY (MEM_LATENCY=2) -> stall 0, all outputs 0; after release a new load completes in 3 cycles.
//  2 Store 0xDEADBEEF @0x10, then load @0x10 -> stall high 2 cycles each; op_read_data=0xDEADBEEF, op_RegWrite=1.
//  3 R-type ALU_result=0x1234, RegWrite=1, dest=5 -> next cycle op_ALU_result=0x1234, op_dest_reg=5, no stall.
//  4 branch=1, zero=1, Add_result=0x3C -> same cycle op_PC_src=1, op_branch_target=0x3C; zero=0 gives op_PC_src=0.
//  5 Load @0x13 -> op_misaligned pulse, no stall, MEM/WB op_RegWrite=0, RAM unchanged.
//  6 ADDR_W=6, store @0x100 then load @0x000 -> wraps to the same word, read returns the stored value.

Source files
------------

// File: rtl/memory_access_stage.sv
// rtl/memory_access_stage.sv - MEM pipeline stage: branch resolve, multi-cycle data RAM, MEM/WB register
module memory_access_stage #(
    parameter int ADDR_W      = 6,
    parameter int MEM_LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] ip_ALU_result,
    input  logic [7:0]  ip_Add_result,
    input  logic [31:0] ip_memory_write_data,
    input  logic [4:0]  ip_dest_reg,
    input  logic        ip_zero,
    input  logic        ip_MemtoReg,
    input  logic        ip_RegWrite,
    input  logic        ip_read_en,
    input  logic        ip_write_en,
    input  logic        ip_branch,
    output logic        op_PC_src,
    output logic [7:0]  op_branch_target,
    output logic        op_stall,
    output logic        op_misaligned,
    output logic [31:0] op_read_data,
    output logic [31:0] op_ALU_result,
    output logic [4:0]  op_dest_reg,
    output logic        op_MemtoReg,
    output logic        op_RegWrite
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = (MEM_LATENCY < 4) ? 2 : $clog2(MEM_LATENCY);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [31:0]        read_data_q, read_data_d;
    logic [31:0]        alu_result_q, alu_result_d;
    logic [4:0]         dest_reg_q, dest_reg_d;
    logic               mem_to_reg_q, mem_to_reg_d;
    logic               reg_write_q, reg_write_d;
    logic               misaligned_q, misaligned_d;

    // Zero at elaboration; never cleared by reset.
    logic [31:0]        mem_q [DEPTH] = '{default: '0};

    logic               acc;
    logic               misaligned;
    logic [ADDR_W-1:0]  idx;
    logic               complete;
    logic               stall_c;

    assign acc        = ip_read_en | ip_write_en;
    assign misaligned = acc & (ip_ALU_result[1:0] != 2'b00);
    assign idx        = ip_ALU_result[ADDR_W+1:2];

    // Branch resolution is purely combinational and independent of the stall.
    assign op_PC_src        = ip_branch & ip_zero;
    assign op_branch_target = ip_Add_result;

    // Reset must release the upstream pipeline even if an access is presented.
    assign op_stall = stall_c & reset;

    // Access sequencing and MEM/WB next-state selection.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        stall_c      = 1'b0;
        complete     = 1'b0;
        misaligned_d = 1'b0;
        read_data_d  = '0;
        alu_result_d = '0;
        dest_reg_d   = '0;
        mem_to_reg_d = 1'b0;
        reg_write_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!acc) begin
                    alu_result_d = ip_ALU_result;
                    dest_reg_d   = ip_dest_reg;
                    mem_to_reg_d = ip_MemtoReg;
                    reg_write_d  = ip_RegWrite;
                end else if (misaligned) begin
                    misaligned_d = 1'b1;
                end else if (MEM_LATENCY == 0) begin
                    complete = 1'b1;
                end else begin
                    stall_c = 1'b1;
                    state_d = BUSY;
                    cnt_d   = CNT_W'(MEM_LATENCY - 1);
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    stall_c = 1'b1;
                    cnt_d   = cnt_q - 1'b1;
                end else begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A combined read+write returns the word as it was before the write.
        if (complete) begin
            read_data_d  = ip_read_en ? mem_q[idx] : 32'h0;
            alu_result_d = ip_ALU_result;
            dest_reg_d   = ip_dest_reg;
            mem_to_reg_d = ip_MemtoReg;
            reg_write_d  = ip_RegWrite;
        end
    end

    // FSM state, wait counter and MEM/WB pipeline register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            read_data_q  <= '0;
            alu_result_q <= '0;
            dest_reg_q   <= '0;
            mem_to_reg_q <= 1'b0;
            reg_write_q  <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            read_data_q  <= read_data_d;
            alu_result_q <= alu_result_d;
            dest_reg_q   <= dest_reg_d;
            mem_to_reg_q <= mem_to_reg_d;
            reg_write_q  <= reg_write_d;
            misaligned_q <= misaligned_d;
        end
    end

    // Store commits only on the completing edge and never while reset is held.
    always_ff @(posedge clock) begin
        if (complete && ip_write_en && reset) begin
            mem_q[idx] <= ip_memory_write_data;
        end
    end

    assign op_read_data  = read_data_q;
    assign op_ALU_result = alu_result_q;
    assign op_dest_reg   = dest_reg_q;
    assign op_MemtoReg   = mem_to_reg_q;
    assign op_RegWrite   = reg_write_q;
    assign op_misaligned = misaligned_q;

endmodule
